// File: rtl/bus_bridge_pkg.sv
// Shared constants for the CPU-to-memory/IO bridge: bus widths, FSM states
// and the value returned to the CPU when a memory access times out.
package bus_bridge_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int IO_ADDR_W = 16;
    localparam int CNT_W     = 10;

    localparam logic [DATA_W-1:0] DEAD_BEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_IO,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bus_bridge_edge_detect.sv
// Registers the CPU request strobe and flags its rising level change.
module bus_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic rise
);

    logic strobe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) strobe_q <= 1'b0;
        else        strobe_q <= strobe;
    end

    assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/bus_bridge.sv
// CPU bus bridge: decodes each strobed request to a memory port (ack-based
// with timeout) or an IO port (fixed wait states) and returns read data.
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IO_BASE     = 32'hFFFF_0000,
    parameter int                IO_WAIT     = 2,
    parameter int                MEM_TIMEOUT = 255
) (
    input  logic                 i_cpu_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bus_clk,
    input  logic                 i_bus_we,
    input  logic [ADDR_W-1:0]    i_bus_addr,
    input  logic [DATA_W-1:0]    i_bus_data,
    output logic [DATA_W-1:0]    o_bus_data,
    output logic                 o_bus_data_ready,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [DATA_W-1:0]    o_mem_wdata,
    input  logic [DATA_W-1:0]    i_mem_rdata,
    input  logic                 i_mem_ack,
    output logic                 o_io_sel,
    output logic                 o_io_we,
    output logic [IO_ADDR_W-1:0] o_io_addr,
    output logic [DATA_W-1:0]    o_io_wdata,
    input  logic [DATA_W-1:0]    i_io_rdata,
    output logic                 o_err,
    output logic                 o_overrun
);

    state_t            state, next_state;
    logic              req_edge;
    logic              accept, mem_done, timeout, io_last;
    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [CNT_W-1:0]  cnt;

    bus_edge_detect u_edge (
        .clk    (i_cpu_clk),
        .rst_n  (i_rst_n),
        .strobe (i_bus_clk),
        .rise   (req_edge)
    );

    always_ff @(posedge i_cpu_clk) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        mem_done   = 1'b0;
        timeout    = 1'b0;
        io_last    = 1'b0;
        o_mem_req  = 1'b0;
        o_io_sel   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_edge) begin
                    accept     = 1'b1;
                    next_state = (i_bus_addr >= IO_BASE) ? ST_IO : ST_MEM;
                end
            end
            ST_MEM: begin
                o_mem_req = 1'b1;
                // An ack in the final counted cycle still completes normally.
                if (i_mem_ack) begin
                    mem_done   = 1'b1;
                    next_state = ST_DONE;
                end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_IO: begin
                o_io_sel = 1'b1;
                if (cnt == CNT_W'(IO_WAIT - 1)) begin
                    io_last    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk) begin
        if (!i_rst_n) begin
            hold_we          <= 1'b0;
            hold_addr        <= '0;
            hold_data        <= '0;
            cnt              <= '0;
            o_bus_data       <= '0;
            o_bus_data_ready <= 1'b1;
            o_err            <= 1'b0;
            o_overrun        <= 1'b0;
        end else begin
            if (accept) begin
                hold_we          <= i_bus_we;
                hold_addr        <= i_bus_addr;
                hold_data        <= i_bus_data;
                o_bus_data_ready <= 1'b0;
            end
            if (req_edge && state != ST_IDLE) o_overrun <= 1'b1;
            if (state == ST_MEM || state == ST_IO) cnt <= cnt + 1'b1;
            else                                   cnt <= '0;
            if (mem_done && !hold_we) o_bus_data <= i_mem_rdata;
            if (io_last && !hold_we)  o_bus_data <= i_io_rdata;
            if (timeout) begin
                o_bus_data <= DEAD_BEEF;
                o_err      <= 1'b1;
            end
            if (state == ST_DONE) o_bus_data_ready <= 1'b1;
        end
    end

    assign o_mem_we    = o_mem_req & hold_we;
    assign o_mem_addr  = hold_addr;
    assign o_mem_wdata = hold_data;
    assign o_io_we     = o_io_sel & hold_we;
    assign o_io_addr   = hold_addr[IO_ADDR_W-1:0];
    assign o_io_wdata  = hold_data;

endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'hFFFF_0000, meaning addresses >= IO_BASE decode to the IO port and all others to the memory port.
REQ-002 SHALL have parameter IO_WAIT, default 2, meaning the fixed IO wait states (range 1..15).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, meaning the max cycles to wait for i_mem_ack (range 1..1023).
REQ-004 SHALL use one clock and a synchronous, active-low reset; ports in order:
 i_cpu_clk  in  1  sole clock, all logic on rising edge
 i_rst_n  in  1  synchronous active-low reset
 i_bus_clk  in  1  CPU request strobe; rising level change = new request
 i_bus_we  in  1  CPU write enable
 i_bus_addr  in  32  CPU address
 i_bus_data  in  32  CPU write data
 o_bus_data  out  32  read data to CPU
 o_bus_data_ready  out  1  transaction complete (level)
 o_mem_req  out  1  memory request
 o_mem_we  out  1  memory write
 o_mem_addr  out  32  memory address
 o_mem_wdata  out  32  memory write data
 i_mem_rdata  in  32  memory read data
 i_mem_ack  in  1  memory acknowledge
 o_io_sel  out  1  IO select
 o_io_we  out  1  IO write
 o_io_addr  out  16  IO offset (captured addr[15:0])
 o_io_wdata  out  32  IO write data
 i_io_rdata  in  32  IO read data
 o_err  out  1  sticky memory timeout flag
 o_overrun  out  1  sticky dropped-request flag

Function
REQ-005 SHALL register i_bus_clk each cycle; a request edge is current=1 and registered=0.
REQ-006 SHALL, on a request edge in IDLE, capture addr/we/data into holding registers, clear o_bus_data_ready the next cycle, and enter MEM or IO per REQ-001.
REQ-007 SHALL implement states IDLE, MEM, IO, DONE; transitions: IDLE->MEM|IO on edge; MEM->DONE on ack or timeout; IO->DONE after IO_WAIT cycles; DONE->IDLE unconditionally.
REQ-008 In MEM, SHALL hold o_mem_req=1 with o_mem_we/addr/wdata from holding registers; deassert the cycle after i_mem_ack is sampled high.
REQ-009 SHALL count MEM cycles; when count reaches MEM_TIMEOUT without ack, drop o_mem_req, load o_bus_data=32'hDEAD_BEEF, set o_err, enter DONE.
REQ-010 On ack of a read, SHALL load o_bus_data from i_mem_rdata in the ack cycle; on write, o_bus_data unchanged.
REQ-011 In IO, SHALL assert o_io_sel for exactly IO_WAIT cycles; read data sampled from i_io_rdata on the last of them.
REQ-012 In DONE, SHALL set o_bus_data_ready=1; it stays 1 through IDLE until the next accepted request.
REQ-013 A request edge outside IDLE SHALL be dropped and set o_overrun; in-flight transaction unaffected.
REQ-014 i_mem_ack outside MEM SHALL be ignored.
REQ-015 Latency edge->ready: IO = IO_WAIT+2 cycles; MEM = ack-wait+2 cycles.
REQ-016 o_mem_req and o_io_sel SHALL never be high simultaneously.

Reset
REQ-017 While i_rst_n=0 at a clock edge: state IDLE, all outputs 0 except o_bus_data_ready=1, counters 0, registered strobe 0, sticky flags cleared.
REQ-018 Reset mid-MEM/IO SHALL abort at once: o_mem_req/o_io_sel low next cycle, no data returned.

Structure
REQ-019 State encodings and DEAD_BEEF constant SHALL live in the shared cpu_inc constants package; widths reuse existing 32-bit width macros.
REQ-020 One sub-module, bus_edge_detect (strobe register + edge output), is natural; all else flat.

Verification
REQ-021 IO read addr 32'hFFFF_0010, i_io_rdata=32'h1234_5678 -> o_io_sel 2 cycles, o_io_addr=16'h0010, ready after 4 cycles, o_bus_data=32'h1234_5678.
REQ-022 Mem write addr 32'h0000_0200, data 32'hA5, ack after 3 cycles -> o_mem_we=1, req deasserts after ack, ready, o_err=0.
REQ-023 Mem read, no ack -> req high 255 cycles, o_bus_data=32'hDEAD_BEEF, o_err=1, ready.
REQ-024 Second edge during MEM wait -> o_overrun=1, first transaction completes normally, second never issued.
REQ-025 i_rst_n low during MEM wait -> o_mem_req 0 next cycle, ready=1, flags 0; next request serviced normally.
